// File: rtl/instr_pkg.sv
// Shared RV32I encoding constants, descriptor class and loader FSM state.
// Also used by the core decoder for the same opcode values.
package instr_pkg;

    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_ILOAD  = 7'b0000011;
    localparam logic [6:0] OP_SSTORE = 7'b0100011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_LSW = 3'b010;

    typedef enum logic [1:0] {
        C_RALU   = 2'd0,
        C_IALU   = 2'd1,
        C_ILOAD  = 2'd2,
        C_SSTORE = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational descriptor-to-RV32I word encoder.
// INSTR_ENCODER_CHECK_EN enables the AluOp legality flag (bad).
module instr_pack
    import instr_pkg::*;
(
    input  logic [1:0]  cls,
    input  logic [3:0]  aluop,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] word,
    output logic        bad
);

    logic [2:0]  f3;
    logic        f7b;
    logic [11:0] imm_i;

    assign f3  = aluop[3:1];
    assign f7b = aluop[0];

    // Shift immediates carry the shamt plus the funct7 arithmetic bit.
    always_comb begin
        imm_i = imm;
        unique case (1'b1)
            f3 == F3_SRX: imm_i = {1'b0, f7b, 5'b0, imm[4:0]};
            f3 == F3_SLL: imm_i = {7'b0, imm[4:0]};
            default:      imm_i = imm;
        endcase
    end

    always_comb begin
        word = '0;
        unique case (1'b1)
            cls == C_RALU:
                word = {1'b0, f7b, 5'b0, rs2, rs1, f3, rd, OP_RALU};
            cls == C_IALU:
                word = {imm_i, rs1, f3, rd, OP_IALU};
            cls == C_ILOAD:
                word = {imm, rs1, F3_LSW, rd, OP_ILOAD};
            default:
                word = {imm[11:5], rs2, rs1, F3_LSW, imm[4:0], OP_SSTORE};
        endcase
    end

`ifdef INSTR_ENCODER_CHECK_EN
    always_comb begin
        bad = 1'b0;
        if (cls == C_IALU && f7b && f3 != F3_SRX)
            bad = 1'b1;
        if (cls == C_RALU && f7b && f3 != F3_ADD && f3 != F3_SRX)
            bad = 1'b1;
    end
`else
    assign bad = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams descriptors into instruction memory as RV32I words.
// Optional INSTR_ENCODER_CHECK_EN flags illegal AluOp codes in err.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [3:0]        in_aluop,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    state_e              state;
    logic [ADDR_W-1:0]   addr;
    logic [31:0]         word;
    logic                held;
    logic [ADDR_W:0]     cnt;
    logic                err_q;
    logic [31:0]         pk_word;
    logic                pk_bad;
    logic                accept;
    logic                ack;

    instr_pack u_pack (
        .cls   (in_class),
        .aluop (in_aluop),
        .rd    (in_rd),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .imm   (in_imm),
        .word  (pk_word),
        .bad   (pk_bad)
    );

    assign in_ready  = (state == S_LOAD) && (!held || mem_ack);
    assign accept    = in_valid && in_ready;
    assign ack       = held && mem_ack;
    assign mem_we    = held;
    assign mem_addr  = addr;
    assign mem_wdata = word;
    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;
    assign count     = cnt;
    assign err       = err_q;

    // A same-edge accept refills the buffer so it never drains mid-stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            addr  <= '0;
            word  <= '0;
            held  <= 1'b0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (ack) begin
                addr <= addr + ADDR_W'(1);
                cnt  <= cnt + (ADDR_W+1)'(1);
                held <= 1'b0;
                if (&addr)
                    err_q <= 1'b1;
            end
            if (accept) begin
                word <= pk_word;
                held <= 1'b1;
                if (pk_bad)
                    err_q <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        addr  <= base_addr;
                        cnt   <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept && in_last)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (ack)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
